// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Central stall / flush / forwarding controller for the 5-stage
//             RV32 pipeline. Sequences the PC, IF/ID, ID/EX, EX/MEM and
//             MEM/WB registers. Handles the post-reset flush, load-use and
//             control hazards, data-memory wait states with a timeout trap,
//             and ALU operand forwarding.
//
//  Parameters
//    INIT_CYCLES  : cycles of post-reset flush before normal issue
//    MEM_TIMEOUT  : consecutive memory-wait cycles before the trap is taken
//
//  Ports
//    clk, rst_n                 : clock, asynchronous active-low reset
//    id_rs1/id_rs2              : sources of the instruction in ID
//    ex_rs1/ex_rs2/ex_rd        : sources / destination of the instruction in EX
//    ex_memread                 : instruction in EX is a load
//    mem_rd/mem_regwrite        : destination / write enable in MEM
//    wb_rd/wb_regwrite          : destination / write enable in WB
//    branch_taken               : branch/jump resolved taken in MEM
//    mem_req/mem_ready          : data-memory access request / completion
//    pcwrite, fdwrite           : PC and IF/ID load enables
//    fdflush                    : IF/ID instruction cleared
//    idex_bubble, exmem_bubble  : NOP injection into ID/EX and EX/MEM
//    pipe_hold                  : ID/EX, EX/MEM, MEM/WB keep contents
//    fwd_a, fwd_b               : ALU operand select (00 RF, 10 EX/MEM, 01 MEM/WB)
//    mem_err                    : sticky memory-timeout trap flag
//    stall_cycles, flush_events : performance counters
//
//  Build option
//    PIPE_CTRL_PERF_EN : when defined, the performance counters are built;
//                        otherwise both counter ports are tied to zero.
//
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pcwrite,
  output logic        fdwrite,
  output logic        fdflush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        pipe_hold,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  // --------------------------------------------------------------------------
  // Counter widths and terminal values
  // --------------------------------------------------------------------------
  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [ICW-1:0] c_init_last = ICW'(INIT_CYCLES - 1);
  // Wait count value in the last tolerated wait cycle; the next edge traps.
  localparam logic [WCW-1:0] c_wait_last = WCW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] c_fwd_rf  = 2'b00;
  localparam logic [1:0] c_fwd_mem = 2'b10;
  localparam logic [1:0] c_fwd_wb  = 2'b01;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_MWAIT = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ICW-1:0]   r_init_cnt;
  logic [WCW-1:0]   r_wait_cnt;

  // --------------------------------------------------------------------------
  // Hazard detection (x0 never matches)
  // --------------------------------------------------------------------------
  logic w_load_use;
  logic w_mem_busy;

  assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign w_mem_busy = mem_req && !mem_ready;

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_INIT && r_init_cnt != c_init_last) begin
        r_init_cnt <= r_init_cnt + ICW'(1);
      end else begin
        r_init_cnt <= '0;
      end

      // The first hold cycle happens in RUN, so the count starts at 1 on entry
      // to MWAIT and equals the number of frozen cycles seen so far.
      if (r_state == S_RUN && w_mem_busy) begin
        r_wait_cnt <= WCW'(1);
      end else if (r_state == S_MWAIT && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + WCW'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and Mealy outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    pcwrite      = 1'b1;
    fdwrite      = 1'b1;
    fdflush      = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    pipe_hold    = 1'b0;
    mem_err      = 1'b0;

    unique case (r_state)
      S_INIT: begin
        pcwrite      = 1'b0;
        fdwrite      = 1'b0;
        fdflush      = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        if (r_init_cnt == c_init_last) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN, S_MWAIT: begin
        // A frozen pipeline masks branch and load-use; both are re-evaluated
        // in the cycle the memory releases the pipeline.
        if ((r_state == S_RUN && w_mem_busy) ||
            (r_state == S_MWAIT && !mem_ready)) begin
          pcwrite   = 1'b0;
          fdwrite   = 1'b0;
          pipe_hold = 1'b1;
          if (r_state == S_RUN) begin
            w_state_nxt = (MEM_TIMEOUT <= 1) ? S_TRAP : S_MWAIT;
          end else if (r_wait_cnt == c_wait_last) begin
            w_state_nxt = S_TRAP;
          end
        end else begin
          w_state_nxt = S_RUN;
          if (branch_taken) begin
            // Flush wins over a simultaneous load-use: the stalled
            // instruction is squashed anyway.
            fdflush      = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
          end else if (w_load_use) begin
            pcwrite     = 1'b0;
            fdwrite     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
      end

      S_TRAP: begin
        pcwrite   = 1'b0;
        fdwrite   = 1'b0;
        pipe_hold = 1'b1;
        mem_err   = 1'b1;
      end

      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand forwarding: MEM result is newer than WB, so it has priority
  // --------------------------------------------------------------------------
  always_comb begin
    fwd_a = c_fwd_rf;
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1) begin
      fwd_a = c_fwd_mem;
    end else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs1) begin
      fwd_a = c_fwd_wb;
    end
  end

  always_comb begin
    fwd_b = c_fwd_rf;
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2) begin
      fwd_b = c_fwd_mem;
    end else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs2) begin
      fwd_b = c_fwd_wb;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
  logic        w_stall_evt;
  logic        w_flush_evt;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  // INIT also drives pcwrite low and fdflush high, but neither counts.
  assign w_stall_evt = !pcwrite && (r_state == S_RUN || r_state == S_MWAIT);
  assign w_flush_evt = fdflush  && (r_state == S_RUN || r_state == S_MWAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall_evt) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush_evt) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
`default_nettype wire
